// File: rtl/wbh_reset_seq_if.sv
// Bus bundle for the reset sequencer: configuration/request inputs and the
// reset, clock-gating and status outputs.
interface wbh_reset_seq_if #(
  parameter int NUM_RST = 4
);
  logic               cfg_fast_sim;
  logic               soft_boot_req;
  logic [NUM_RST-1:0] cfg_rst_mask;
  logic               p_reset_n;
  logic [NUM_RST-1:0] s_reset_n;
  logic               clk_enb;
  logic               force_refclk;
  logic               soft_reboot;
  logic               seq_busy;
  logic [7:0]         boot_cnt;

  modport master (
    output cfg_fast_sim, soft_boot_req, cfg_rst_mask,
    input  p_reset_n, s_reset_n, clk_enb, force_refclk, soft_reboot,
           seq_busy, boot_cnt
  );

  modport slave (
    input  cfg_fast_sim, soft_boot_req, cfg_rst_mask,
    output p_reset_n, s_reset_n, clk_enb, force_refclk, soft_reboot,
           seq_busy, boot_cnt
  );
endinterface

// File: rtl/wbh_reset_seq.sv
// Power-up and soft-reboot reset sequencer: walks clock enable, power-on
// reset, reference-clock release and per-domain soft resets in fixed steps.
module wbh_reset_seq #(
  parameter int NUM_RST        = 4,
  parameter int CNT_W          = 16,
  parameter int PWRUP_CNT      = 60000,
  parameter int PWRUP_CNT_FAST = 100,
  parameter int STEP_CNT       = 15
) (
  input  logic           clk,
  input  logic           e_reset_n,
  wbh_reset_seq_if.slave bus
);

  localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  typedef enum logic [2:0] {
    PWR_UP,
    CLK_ENB,
    POR_REL,
    FORCE_REL,
    SRST_REL,
    IDLE,
    RB_CLK_OFF,
    RB_ASSERT
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               pend_q;
  logic [2:0]         sync_q;
  logic               p_reset_n_q;
  logic [NUM_RST-1:0] s_reset_n_q;
  logic               clk_enb_q;
  logic               force_refclk_q;
  logic               soft_reboot_q;
  logic               seq_busy_q;
  logic [7:0]         boot_cnt_q;

  logic req_rise;
  logic step_done;
  logic pwr_done;

  // sync_q[1] is the synchronised request, sync_q[2] its previous value
  assign req_rise  = sync_q[1] & ~sync_q[2];
  assign step_done = (cnt_q == CNT_W'(STEP_CNT));
  assign pwr_done  = bus.cfg_fast_sim ? (cnt_q == CNT_W'(PWRUP_CNT_FAST))
                                      : (cnt_q == CNT_W'(PWRUP_CNT));

  always_ff @(posedge clk or negedge e_reset_n) begin
    if (!e_reset_n) begin
      state_q        <= PWR_UP;
      cnt_q          <= '0;
      idx_q          <= '0;
      pend_q         <= 1'b0;
      sync_q         <= '0;
      p_reset_n_q    <= 1'b0;
      s_reset_n_q    <= '0;
      clk_enb_q      <= 1'b0;
      force_refclk_q <= 1'b1;
      soft_reboot_q  <= 1'b0;
      seq_busy_q     <= 1'b1;
      boot_cnt_q     <= '0;
    end else begin
      sync_q <= {sync_q[1:0], bus.soft_boot_req};
      cnt_q  <= cnt_q + CNT_W'(1);
      if (req_rise && (state_q != IDLE)) pend_q <= 1'b1;

      case (state_q)
        PWR_UP: if (pwr_done) begin
          state_q <= CLK_ENB;
          cnt_q   <= '0;
        end
        CLK_ENB: if (step_done) begin
          clk_enb_q <= 1'b1;
          state_q   <= POR_REL;
          cnt_q     <= '0;
        end
        POR_REL: if (step_done) begin
          p_reset_n_q <= 1'b1;
          state_q     <= FORCE_REL;
          cnt_q       <= '0;
        end
        FORCE_REL: if (step_done) begin
          force_refclk_q <= 1'b0;
          idx_q          <= '0;
          state_q        <= SRST_REL;
          cnt_q          <= '0;
        end
        SRST_REL: if (step_done) begin
          s_reset_n_q[idx_q] <= 1'b1;
          cnt_q              <= '0;
          if (idx_q == IDX_W'(NUM_RST - 1)) begin
            idx_q      <= '0;
            state_q    <= IDLE;
            seq_busy_q <= 1'b0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        IDLE: begin
          cnt_q <= '0;
          if (pend_q || req_rise) begin
            pend_q         <= 1'b0;
            state_q        <= RB_CLK_OFF;
            clk_enb_q      <= 1'b0;
            force_refclk_q <= 1'b1;
            soft_reboot_q  <= 1'b1;
            seq_busy_q     <= 1'b1;
            if (boot_cnt_q != 8'hFF) boot_cnt_q <= boot_cnt_q + 8'd1;
          end
        end
        RB_CLK_OFF: if (step_done) begin
          state_q <= RB_ASSERT;
          cnt_q   <= '0;
        end
        // Mask is sampled only here; clocks come back together with the resets.
        RB_ASSERT: if (step_done) begin
          s_reset_n_q <= s_reset_n_q & ~bus.cfg_rst_mask;
          clk_enb_q   <= 1'b1;
          state_q     <= FORCE_REL;
          cnt_q       <= '0;
        end
        default: begin
          state_q    <= PWR_UP;
          cnt_q      <= '0;
          seq_busy_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.p_reset_n    = p_reset_n_q;
  assign bus.s_reset_n    = s_reset_n_q;
  assign bus.clk_enb      = clk_enb_q;
  assign bus.force_refclk = force_refclk_q;
  assign bus.soft_reboot  = soft_reboot_q;
  assign bus.seq_busy     = seq_busy_q;
  assign bus.boot_cnt     = boot_cnt_q;

endmodule

// File: tb/tb_wbh_reset_seq.sv
// Randomised bench for wbh_reset_seq: outputs are compared every cycle with
// a timeline model derived from the step durations of each phase.
module tb_wbh_reset_seq;

  localparam int NR = 4;
  localparam int ST = 15;
  localparam int S1 = ST + 1;
  localparam int PF = 100;
  localparam int PS = 300;
  localparam int OW = NR + 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wbh_reset_seq_if #(.NUM_RST(NR)) bus();

  wbh_reset_seq #(
    .NUM_RST(NR),
    .CNT_W(16),
    .PWRUP_CNT(PS),
    .PWRUP_CNT_FAST(PF),
    .STEP_CNT(ST)
  ) dut (
    .clk(clk),
    .e_reset_n(rst_n),
    .bus(bus.slave)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // model state: edges since reset release, start edge of the current phase
  int unsigned   cyc, base, pterm, cnt_m, hunt_start;
  bit            rb, sr_m, pend, hunt;
  logic [NR-1:0] s_prev, m_mask;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned busy_len();
    if (rb) return (3 + NR) * S1;
    return pterm + 1 + S1 + (2 + NR) * S1;
  endfunction

  function automatic logic [OW-1:0] exp_outs();
    int unsigned n = cyc - base;
    int unsigned tce = pterm + 1 + S1;
    logic ce, p, fr, b;
    logic [NR-1:0] s;
    if (!rb) begin
      ce = (n >= tce);
      p  = (n >= tce + S1);
      fr = (n < tce + 2 * S1);
      for (int unsigned i = 0; i < NR; i++) s[i] = (n >= tce + (3 + i) * S1);
    end else begin
      ce = (n >= 2 * S1);
      p  = 1'b1;
      fr = (n < 3 * S1);
      for (int unsigned i = 0; i < NR; i++) begin
        if (n >= (4 + i) * S1)  s[i] = 1'b1;
        else if (n >= 2 * S1)   s[i] = s_prev[i] & ~m_mask[i];
        else                    s[i] = s_prev[i];
      end
    end
    b = (n < busy_len());
    return {p, s, ce, fr, sr_m, b, cnt_m[7:0]};
  endfunction

  function automatic logic [OW-1:0] dut_outs();
    return {bus.p_reset_n, bus.s_reset_n, bus.clk_enb, bus.force_refclk,
            bus.soft_reboot, bus.seq_busy, bus.boot_cnt};
  endfunction

  task automatic start_reboot();
    logic [OW-1:0] e = exp_outs();
    s_prev = e[OW-2 -: NR];
    rb     = 1'b1;
    base   = cyc;
    sr_m   = 1'b1;
    pend   = 1'b0;
    if (cnt_m < 255) cnt_m++;
  endtask

  task automatic tick();
    logic lat_ok;
    @(posedge clk);
    #1;
    cyc++;
    if (rb && (cyc - base == 2 * S1)) m_mask = bus.cfg_rst_mask;
    if (hunt) begin
      if (bus.clk_enb === 1'b0) begin
        hunt   = 1'b0;
        lat_ok = ((cyc - hunt_start) >= 2) && ((cyc - hunt_start) <= 5);
        check("req_latency", {31'd0, lat_ok}, 32'd1);
        start_reboot();
      end else if (cyc - hunt_start >= 8) begin
        hunt = 1'b0;
        check("req_timeout", 32'd0, 32'd1);
      end
    end else if (pend && (cyc == base + busy_len() + 1)) begin
      start_reboot();
    end
    check("outs", 32'(dut_outs()), 32'(exp_outs()));
  endtask

  task automatic do_reset(input bit fast);
    rst_n = 1'b0;
    bus.cfg_fast_sim = fast;
    #1;
    cyc = 0; base = 0; rb = 1'b0; sr_m = 1'b0; cnt_m = 0;
    pend = 1'b0; hunt = 1'b0;
    pterm = fast ? PF : PS;
    check("rst_async", 32'(dut_outs()), 32'(exp_outs()));
    repeat (3) @(negedge clk);
    check("rst_hold", 32'(dut_outs()), 32'(exp_outs()));
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int unsigned extra);
    int unsigned guard = 0;
    while ((pend || cyc < base + busy_len() + extra) && guard < 3000) begin
      tick();
      guard++;
    end
    if (guard >= 3000) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_pend();
    bus.soft_boot_req = 1'b1;
    pend = 1'b1;
    repeat (4) tick();
    bus.soft_boot_req = 1'b0;
    repeat (4) tick();
  endtask

  task automatic idle_reboot(input logic [NR-1:0] mask);
    bus.cfg_rst_mask  = mask;
    bus.soft_boot_req = 1'b1;
    hunt = 1'b1;
    hunt_start = cyc;
    repeat (4) tick();
    bus.soft_boot_req = 1'b0;
    for (int k = 0; k < 10 && hunt; k++) tick();
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    bus.soft_boot_req = 1'b0;
    bus.cfg_rst_mask  = '0;
    bus.cfg_fast_sim  = 1'b1;
    #12;

    // cold boot with three requests merged into one pending reboot
    do_reset(1'b1);
    bus.cfg_rst_mask = NR'($urandom_range(0, 15));
    repeat (50) tick();
    pulse_pend();
    repeat (20) tick();
    pulse_pend();
    repeat (30) tick();
    pulse_pend();
    wait_idle(3);
    check("merged_boot_cnt", 32'(bus.boot_cnt), 32'd1);

    idle_reboot(4'b0101);
    wait_idle(5);
    idle_reboot(4'b0000);
    wait_idle(5);

    for (int it = 0; it < 10; it++) begin
      idle_reboot(NR'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(2, 25)) tick();
        bus.cfg_rst_mask = NR'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 40)) tick();
        pulse_pend();
      end
      wait_idle($urandom_range(1, 20));
    end

    // external reset in the middle of RB_ASSERT
    idle_reboot(NR'($urandom_range(1, 15)));
    while (cyc - base < 24) tick();
    #2;
    do_reset(1'b1);
    check("boot_cnt_after_rst", 32'(bus.boot_cnt), 32'd0);
    wait_idle(3);

    for (int it = 0; it < 256; it++) begin
      idle_reboot(NR'($urandom_range(0, 15)));
      wait_idle($urandom_range(1, 4));
    end
    check("boot_cnt_sat", 32'(bus.boot_cnt), 32'd255);

    // slow power-up count
    do_reset(1'b0);
    wait_idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
